// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
//   Miss handler for the 4-way set-associative cache. Detects a miss from the
//   per-way hit vector, stalls the CPU, issues a line-aligned burst read,
//   streams the returned beats into the data array and finally pulses
//   read_main_memory_en so the tag array installs the tag into the LRU way.
//
//   Optional build feature (macro REFILL_TIMEOUT_EN):
//     defined   - a beat-gap watchdog aborts a stalled refill after
//                 TIMEOUT_CYCLES idle cycles in REQ/FILL and pulses refill_err.
//     undefined - no watchdog; refill_err is tied low and the FSM waits
//                 indefinitely for the memory.
// -----------------------------------------------------------------------------
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int OFFSET_WIDTH   = 4,
    parameter int LINE_WORDS     = 4,
    parameter int WAY_NUM        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cache_en,
    input  logic                      req_valid,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [WAY_NUM-1:0]        hit_en,
    output logic                      cpu_stall,
    output logic                      mem_rd_req,
    output logic [ADDR_WIDTH-1:0]     mem_rd_addr,
    input  logic                      mem_rd_ack,
    input  logic                      mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data,
    output logic                      refill_we,
    output logic [((LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1)-1:0] refill_word_idx,
    output logic [DATA_WIDTH-1:0]     refill_data,
    output logic                      read_main_memory_en,
    output logic                      refill_err,
    output logic [15:0]               miss_count
);

    localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_WIDTH;

    // An inconsistent line geometry never starts a refill, so a mis-parameterised
    // instance shows up as a cache that never fills rather than corrupt lines.
    localparam bit CFG_OK = (LINE_WORDS * DATA_WIDTH == (2 ** OFFSET_WIDTH) * 8)
                         && ((LINE_WORDS & (LINE_WORDS - 1)) == 0)
                         && (WAY_NUM > 0)
                         && (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [IDX_W-1:0]        beat_q, beat_d;
    logic                    miss;
    logic                    timeout;

    // Any nonzero hit vector, even multi-bit, is treated as a hit.
    assign miss = CFG_OK && cache_en && req_valid && (hit_en == '0);

    assign mem_rd_addr     = addr_q;
    assign refill_word_idx = beat_q;

`ifdef REFILL_TIMEOUT_EN
    localparam int GAP_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [GAP_W-1:0] gap_q;
    logic             progress;
    logic             waiting;

    assign waiting  = (state_q == REQ) || (state_q == FILL);
    assign progress = ((state_q == REQ) && mem_rd_ack) || ((state_q == FILL) && mem_rd_valid);
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without an ack or beat.
    assign timeout  = waiting && !progress && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

    // Beat-gap watchdog: counts idle cycles while waiting on the memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= '0;
        end else if (waiting && !progress && !timeout) begin
            gap_q <= gap_q + GAP_W'(1);
        end else begin
            gap_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State, beat counter, latched line address and saturating miss counter.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            addr_q     <= '0;
            miss_count <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if ((state_q == IDLE) && miss) begin
                addr_q <= req_addr & LINE_MASK;
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end

    // Next-state and output decode.
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d             = state_q;
        beat_d              = beat_q;
        cpu_stall           = 1'b0;
        mem_rd_req          = 1'b0;
        refill_we           = 1'b0;
        refill_data         = '0;
        read_main_memory_en = 1'b0;
        refill_err          = 1'b0;

        unique case (state_q)
            IDLE: begin
                cpu_stall = miss;
                if (miss) begin
                    state_d = REQ;
                end
            end

            REQ: begin
                cpu_stall = 1'b1;
                if (timeout) begin
                    refill_err = 1'b1;
                    beat_d     = '0;
                    state_d    = IDLE;
                end else begin
                    mem_rd_req = 1'b1;
                    if (mem_rd_ack) begin
                        beat_d  = '0;
                        state_d = FILL;
                    end
                end
            end

            FILL: begin
                cpu_stall   = 1'b1;
                refill_we   = mem_rd_valid;
                refill_data = mem_rd_data;
                if (timeout) begin
                    refill_err = 1'b1;
                    beat_d     = '0;
                    state_d    = IDLE;
                end else if (mem_rd_valid) begin
                    beat_d = beat_q + IDX_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = COMMIT;
                    end
                end
            end

            COMMIT: begin
                cpu_stall           = 1'b1;
                read_main_memory_en = 1'b1;
                state_d             = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
//   Directed bench for cache_refill_ctrl. Inputs change just after the falling
//   edge and outputs are sampled 1 ns later, well clear of the rising edge.
//   Building with REFILL_TIMEOUT_EN runs the watchdog scenario with an 8-cycle
//   limit; the default build checks that the FSM waits indefinitely instead.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

`ifdef REFILL_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic        clk;
    logic        rst;
    logic        cache_en;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  hit_en;
    logic        cpu_stall;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        refill_we;
    logic [1:0]  refill_word_idx;
    logic [31:0] refill_data;
    logic        read_main_memory_en;
    logic        refill_err;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_fails  = 0;

    cache_refill_ctrl #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .OFFSET_WIDTH  (4),
        .LINE_WORDS    (4),
        .WAY_NUM       (4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cache_en           (cache_en),
        .req_valid          (req_valid),
        .req_addr           (req_addr),
        .hit_en             (hit_en),
        .cpu_stall          (cpu_stall),
        .mem_rd_req         (mem_rd_req),
        .mem_rd_addr        (mem_rd_addr),
        .mem_rd_ack         (mem_rd_ack),
        .mem_rd_valid       (mem_rd_valid),
        .mem_rd_data        (mem_rd_data),
        .refill_we          (refill_we),
        .refill_word_idx    (refill_word_idx),
        .refill_data        (refill_data),
        .read_main_memory_en(read_main_memory_en),
        .refill_err         (refill_err),
        .miss_count         (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every output packed together; all of them must be zero after reset.
    function automatic logic [119:0] all_outputs();
        return {cpu_stall, mem_rd_req, mem_rd_addr, refill_we, refill_word_idx,
                refill_data, read_main_memory_en, refill_err, miss_count};
    endfunction

    task automatic test_reset();
        rst = 1'b1; cache_en = 1'b0; req_valid = 1'b0; req_addr = '0; hit_en = '0;
        mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (all_outputs() !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got %h want 0", all_outputs());
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_hit_path();
        logic [3:0] pats [3];
        pats[0] = 4'b0100; pats[1] = 4'b1111; pats[2] = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); cache_en = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_4000; hit_en = pats[i];
            #1;
            n_checks++;
            if ({cpu_stall, mem_rd_req} !== 2'b00) begin
                n_fails++;
                $display("FAIL hit_no_stall[%0d]: got stall=%b req=%b want 0 0", i, cpu_stall, mem_rd_req);
            end
        end
        // Miss pattern while the cache is disabled: no stall, no request.
        @(negedge clk); cache_en = 1'b0; hit_en = 4'b0000; #1;
        n_checks++;
        if (cpu_stall !== 1'b0) begin
            n_fails++;
            $display("FAIL disabled_no_stall: got %b want 0", cpu_stall);
        end
        @(negedge clk); req_valid = 1'b0; cache_en = 1'b1; #1;
        n_checks++;
        if ({mem_rd_req, miss_count} !== 17'h0) begin
            n_fails++;
            $display("FAIL hit_no_miss: got req=%b count=%0d want 0 0", mem_rd_req, miss_count);
        end
    endtask

    // One complete refill; gap_len idle cycles are inserted before beat gap_at.
    task automatic run_refill(input string tag, input logic [31:0] addr, input logic [31:0] line,
                              input logic [31:0] base, input int gap_at, input int gap_len,
                              input bit drop_en, input bit stray, input logic [15:0] exp_cnt);
        // Miss cycle: combinational stall, no request yet.
        @(negedge clk); cache_en = 1'b1; req_valid = 1'b1; req_addr = addr; hit_en = 4'b0000;
        mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; #1;
        n_checks++;
        if ({cpu_stall, mem_rd_req} !== 2'b10) begin
            n_fails++;
            $display("FAIL %s miss_cycle: got stall=%b req=%b want 1 0", tag, cpu_stall, mem_rd_req);
        end
        // REQ without ack; changed req_addr and a stray beat must both be ignored.
        @(negedge clk); req_addr = addr ^ 32'hFFFF_0000; mem_rd_valid = stray; mem_rd_data = 32'hDEAD_BEEF; #1;
        n_checks++;
        if ({mem_rd_req, refill_we, mem_rd_addr} !== {2'b10, line}) begin
            n_fails++;
            $display("FAIL %s req_wait: got req=%b we=%b addr=%h want 1 0 %h", tag, mem_rd_req, refill_we, mem_rd_addr, line);
        end
        // REQ with ack.
        @(negedge clk); mem_rd_ack = 1'b1; #1;
        n_checks++;
        if ({mem_rd_req, refill_we} !== 2'b10) begin
            n_fails++;
            $display("FAIL %s req_ack: got req=%b we=%b want 1 0", tag, mem_rd_req, refill_we);
        end
        for (int b = 0; b < 4; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk); mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; #1;
                    n_checks++;
                    if ({refill_we, cpu_stall, read_main_memory_en} !== 3'b010) begin
                        n_fails++;
                        $display("FAIL %s gap[%0d]: got we=%b stall=%b commit=%b want 0 1 0", tag, g, refill_we, cpu_stall, read_main_memory_en);
                    end
                end
            end
            @(negedge clk); mem_rd_ack = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = base + 32'(b);
            if (drop_en) cache_en = 1'b0;
            #1;
            n_checks++;
            if ({mem_rd_req, refill_we, refill_word_idx, refill_data, read_main_memory_en} !==
                {1'b0, 1'b1, 2'(b), base + 32'(b), 1'b0}) begin
                n_fails++;
                $display("FAIL %s beat[%0d]: got req=%b we=%b idx=%0d data=%h commit=%b want 0 1 %0d %h 0",
                         tag, b, mem_rd_req, refill_we, refill_word_idx, refill_data, read_main_memory_en, b, base + 32'(b));
            end
        end
        // COMMIT: single tag-install pulse, still stalled.
        @(negedge clk); mem_rd_valid = 1'b0; #1;
        n_checks++;
        if ({read_main_memory_en, cpu_stall, refill_we, refill_err} !== 4'b1100) begin
            n_fails++;
            $display("FAIL %s commit: got commit=%b stall=%b we=%b err=%b want 1 1 0 0", tag, read_main_memory_en, cpu_stall, refill_we, refill_err);
        end
        // Back in IDLE: the re-lookup hits, stall releases.
        @(negedge clk); hit_en = 4'b0001; cache_en = 1'b1; #1;
        n_checks++;
        if ({read_main_memory_en, cpu_stall, miss_count} !== {2'b00, exp_cnt}) begin
            n_fails++;
            $display("FAIL %s release: got commit=%b stall=%b count=%0d want 0 0 %0d", tag, read_main_memory_en, cpu_stall, miss_count, exp_cnt);
        end
        @(negedge clk); req_valid = 1'b0; hit_en = 4'b0000;
    endtask

    task automatic test_stray_beat_idle();
        @(negedge clk); req_valid = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 32'h0000_DEAD; #1;
        n_checks++;
        if ({refill_we, mem_rd_req, cpu_stall} !== 3'b000) begin
            n_fails++;
            $display("FAIL stray_idle: got we=%b req=%b stall=%b want 0 0 0", refill_we, mem_rd_req, cpu_stall);
        end
        mem_rd_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        @(negedge clk); cache_en = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_2468; hit_en = 4'b0000;
        @(negedge clk); mem_rd_ack = 1'b1;
        @(negedge clk); mem_rd_ack = 1'b0; mem_rd_valid = 1'b1; mem_rd_data = 32'h11;
        @(negedge clk); mem_rd_data = 32'h22; #1;
        n_checks++;
        if ({refill_we, refill_word_idx} !== 3'b101) begin
            n_fails++;
            $display("FAIL midrst_beat1: got we=%b idx=%0d want 1 1", refill_we, refill_word_idx);
        end
        @(negedge clk); rst = 1'b1; mem_rd_valid = 1'b0; req_valid = 1'b0;
        @(negedge clk); rst = 1'b0; #1;
        n_checks++;
        if (all_outputs() !== '0) begin
            n_fails++;
            $display("FAIL midrst_outputs: got %h want 0", all_outputs());
        end
        @(negedge clk); #1;
        n_checks++;
        if ({read_main_memory_en, cpu_stall, mem_rd_req} !== 3'b000) begin
            n_fails++;
            $display("FAIL midrst_no_commit: got commit=%b stall=%b req=%b want 0 0 0", read_main_memory_en, cpu_stall, mem_rd_req);
        end
    endtask

`ifdef REFILL_TIMEOUT_EN
    task automatic test_timeout();
        int err_at = -1;
        int commits = 0;
        @(negedge clk); cache_en = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_3004; hit_en = 4'b0000;
        @(negedge clk); mem_rd_ack = 1'b1;
        for (int k = 1; k <= 20 && err_at < 0; k++) begin
            @(negedge clk); mem_rd_ack = 1'b0; #1;
            if (read_main_memory_en === 1'b1) commits++;
            if (refill_err === 1'b1) err_at = k;
        end
        n_checks++;
        if (err_at != 8 || commits != 0) begin
            n_fails++;
            $display("FAIL timeout_pulse: got err_cycle=%0d commits=%0d want 8 0", err_at, commits);
        end
        // IDLE again with the miss still presented; pulse is gone.
        @(negedge clk); #1;
        n_checks++;
        if ({refill_err, cpu_stall, mem_rd_req, read_main_memory_en} !== 4'b0100) begin
            n_fails++;
            $display("FAIL timeout_idle: got err=%b stall=%b req=%b commit=%b want 0 1 0 0", refill_err, cpu_stall, mem_rd_req, read_main_memory_en);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({mem_rd_req, miss_count} !== {1'b1, 16'd2}) begin
            n_fails++;
            $display("FAIL timeout_remiss: got req=%b count=%0d want 1 2", mem_rd_req, miss_count);
        end
        @(negedge clk); rst = 1'b1; req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        int errs = 0;
        @(negedge clk); cache_en = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_3004; hit_en = 4'b0000;
        @(negedge clk); mem_rd_ack = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); mem_rd_ack = 1'b0; #1;
            if (refill_err !== 1'b0) errs++;
        end
        n_checks++;
        if (errs != 0 || {cpu_stall, mem_rd_req, miss_count} !== {2'b10, 16'd1}) begin
            n_fails++;
            $display("FAIL no_timeout_wait: got errs=%0d stall=%b req=%b count=%0d want 0 1 0 1", errs, cpu_stall, mem_rd_req, miss_count);
        end
        @(negedge clk); rst = 1'b1; req_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_hit_path();
        run_refill("basic",  32'h0000_1234, 32'h0000_1230, 32'h0000_00A0, 0, 0, 1'b0, 1'b0, 16'd1);
        run_refill("gapped", 32'h0000_5678, 32'h0000_5670, 32'h0000_00B0, 2, 3, 1'b0, 1'b0, 16'd2);
        test_stray_beat_idle();
        run_refill("cen_drop", 32'h0000_9ABC, 32'h0000_9AB0, 32'h0000_00C0, 0, 0, 1'b1, 1'b1, 16'd3);
        test_mid_reset();
`ifdef REFILL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "time limit");
    end

endmodule
